// File: rtl/noc2_resp_deframer.sv
// NoC2 response deframer: rebuilds a header flit plus payload flits into one decoded response.
// Optional destination filtering is compiled in with NOC2_DEFRAMER_DEST_CHECK_EN.
module noc2_resp_deframer #(
    parameter int MAX_PAYLOAD = 2,
    parameter int FLIT_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              noc2_valid_in,
    input  logic [FLIT_W-1:0] noc2_data_in,
    output logic              noc2_ready_out,
    input  logic [13:0]       chipid,
    input  logic [7:0]        coreid_x,
    input  logic [7:0]        coreid_y,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic [7:0]        msg_type,
    output logic [7:0]        msg_mshrid,
    output logic [7:0]        msg_len,
    output logic [127:0]      msg_data,
    output logic              msg_err,
    output logic              drop_pulse
);

    if (FLIT_W != 64) begin : g_bad_flit_w
        $error("noc2_resp_deframer: only FLIT_W=64 is supported");
    end
    if (MAX_PAYLOAD > 2) begin : g_bad_max_payload
        $error("noc2_resp_deframer: MAX_PAYLOAD must be <= 2 for a 128-bit msg_data");
    end

    localparam logic [7:0] MAX_PAYLOAD_W = 8'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] rem;
    logic       dropping;

    logic       flit_xfer;
    logic [7:0] hdr_len;
    logic       hdr_drop;

    assign flit_xfer = noc2_valid_in && noc2_ready_out;
    assign hdr_len   = noc2_data_in[29:22];

`ifdef NOC2_DEFRAMER_DEST_CHECK_EN
    assign hdr_drop = {noc2_data_in[63:50], noc2_data_in[49:42], noc2_data_in[41:34]}
                      != {chipid, coreid_x, coreid_y};
`else
    assign hdr_drop = 1'b0;
    logic unused_dest;
    assign unused_dest = &{1'b0, chipid, coreid_x, coreid_y};
`endif

    // NOTE: every register here is written with <= so all state updates of a
    // cycle see the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            noc2_ready_out <= 1'b1;
            msg_valid      <= 1'b0;
            msg_type       <= '0;
            msg_mshrid     <= '0;
            msg_len        <= '0;
            msg_data       <= '0;
            msg_err        <= 1'b0;
            drop_pulse     <= 1'b0;
            cnt            <= '0;
            rem            <= '0;
            dropping       <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flit_xfer) begin
                        cnt      <= '0;
                        rem      <= hdr_len;
                        dropping <= hdr_drop;
                        // A dropped message leaves the previous response fields untouched.
                        if (!hdr_drop) begin
                            msg_type   <= noc2_data_in[21:14];
                            msg_mshrid <= noc2_data_in[13:6];
                            msg_len    <= hdr_len;
                            msg_data   <= '0;
                            msg_err    <= (hdr_len > MAX_PAYLOAD_W);
                        end
                        if (hdr_len == 8'd0) begin
                            if (hdr_drop) begin
                                drop_pulse <= 1'b1;
                            end else begin
                                state          <= S_OUT;
                                msg_valid      <= 1'b1;
                                noc2_ready_out <= 1'b0;
                            end
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (flit_xfer) begin
                        if (!dropping) begin
                            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                                if (cnt == 3'(i)) msg_data[64*i +: 64] <= noc2_data_in;
                            end
                        end
                        if (cnt != 3'd7) cnt <= cnt + 3'd1;
                        rem <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            if (dropping) begin
                                state      <= S_IDLE;
                                drop_pulse <= 1'b1;
                            end else begin
                                state          <= S_OUT;
                                msg_valid      <= 1'b1;
                                noc2_ready_out <= 1'b0;
                            end
                        end
                    end
                end

                S_OUT: begin
                    if (msg_ready) begin
                        state          <= S_IDLE;
                        msg_valid      <= 1'b0;
                        noc2_ready_out <= 1'b1;
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    msg_valid      <= 1'b0;
                    noc2_ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc2_resp_deframer.sv
// Directed self-checking bench for noc2_resp_deframer; inputs driven and outputs sampled on negedge.
module tb_noc2_resp_deframer;

    logic         clk;
    logic         rst;
    logic         noc2_valid_in;
    logic [63:0]  noc2_data_in;
    logic         noc2_ready_out;
    logic [13:0]  chipid;
    logic [7:0]   coreid_x;
    logic [7:0]   coreid_y;
    logic         msg_valid;
    logic         msg_ready;
    logic [7:0]   msg_type;
    logic [7:0]   msg_mshrid;
    logic [7:0]   msg_len;
    logic [127:0] msg_data;
    logic         msg_err;
    logic         drop_pulse;

    int total = 0;
    int bad   = 0;

    noc2_resp_deframer #(.MAX_PAYLOAD(2), .FLIT_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .noc2_valid_in (noc2_valid_in),
        .noc2_data_in  (noc2_data_in),
        .noc2_ready_out(noc2_ready_out),
        .chipid        (chipid),
        .coreid_x      (coreid_x),
        .coreid_y      (coreid_y),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_type      (msg_type),
        .msg_mshrid    (msg_mshrid),
        .msg_len       (msg_len),
        .msg_data      (msg_data),
        .msg_err       (msg_err),
        .drop_pulse    (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] mk_hdr(input logic [7:0] x, input logic [7:0] len,
                                           input logic [7:0] typ, input logic [7:0] mshr);
        mk_hdr = {14'd0, x, 8'd0, 4'd0, len, typ, mshr, 6'd0};
    endfunction

    // Called on a negedge; returns on the negedge after the flit transferred.
    task automatic send_flit(input logic [63:0] d);
        int waited = 0;
        noc2_valid_in = 1'b1;
        noc2_data_in  = d;
        while (!noc2_ready_out && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!noc2_ready_out) begin
            bad++;
            $display("FAIL send_flit_timeout ready_out got=%0b want=1 after %0d cycles", noc2_ready_out, waited);
        end
        @(negedge clk);
        noc2_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (noc2_ready_out !== 1'b1 || msg_valid !== 1'b0 || drop_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl ready/valid/drop got=%0b%0b%0b want=100", noc2_ready_out, msg_valid, drop_pulse);
        end
        total++;
        if (msg_type !== 8'h00 || msg_mshrid !== 8'h00 || msg_len !== 8'h00 || msg_data !== 128'h0 || msg_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_fields type=%h mshr=%h len=%h data=%h err=%0b want all 0",
                     msg_type, msg_mshrid, msg_len, msg_data, msg_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_len0();
        msg_ready = 1'b1;
        send_flit(mk_hdr(8'd0, 8'd0, 8'h1F, 8'h05));
        total++;
        if (msg_valid !== 1'b1 || noc2_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL len0_valid valid/ready got=%0b%0b want=10", msg_valid, noc2_ready_out);
        end
        total++;
        if (msg_type !== 8'h1F || msg_mshrid !== 8'h05 || msg_len !== 8'h00 || msg_data !== 128'h0 || msg_err !== 1'b0) begin
            bad++;
            $display("FAIL len0_fields type=%h mshr=%h len=%h data=%h err=%0b want 1f 05 00 0 0",
                     msg_type, msg_mshrid, msg_len, msg_data, msg_err);
        end
        @(negedge clk);
        total++;
        if (msg_valid !== 1'b0 || noc2_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL len0_accept valid/ready got=%0b%0b want=01", msg_valid, noc2_ready_out);
        end
        msg_ready = 1'b0;
    endtask

    task automatic test_len2();
        send_flit(mk_hdr(8'd0, 8'd2, 8'h07, 8'h2A));
        total++;
        if (msg_valid !== 1'b0) begin
            bad++;
            $display("FAIL len2_after_hdr valid got=%0b want=0", msg_valid);
        end
        send_flit(64'hAAAA_AAAA_AAAA_AAAA);
        total++;
        if (msg_valid !== 1'b0) begin
            bad++;
            $display("FAIL len2_after_flit0 valid got=%0b want=0", msg_valid);
        end
        send_flit(64'h5555_5555_5555_5555);
        total++;
        if (msg_valid !== 1'b1 || msg_len !== 8'd2 || msg_err !== 1'b0 || msg_type !== 8'h07 || msg_mshrid !== 8'h2A) begin
            bad++;
            $display("FAIL len2_hdr valid=%0b len=%0d err=%0b type=%h mshr=%h want 1 2 0 07 2a",
                     msg_valid, msg_len, msg_err, msg_type, msg_mshrid);
        end
        total++;
        if (msg_data !== 128'h5555_5555_5555_5555_AAAA_AAAA_AAAA_AAAA) begin
            bad++;
            $display("FAIL len2_data got=%h want=5555555555555555aaaaaaaaaaaaaaaa", msg_data);
        end
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;
        total++;
        if (msg_valid !== 1'b0) begin
            bad++;
            $display("FAIL len2_accept valid got=%0b want=0", msg_valid);
        end
    endtask

    task automatic test_overflow();
        send_flit(mk_hdr(8'd0, 8'd4, 8'h0C, 8'h33));
        send_flit(64'h1111_0000_0000_0001);
        send_flit(64'h2222_0000_0000_0002);
        send_flit(64'h3333_0000_0000_0003);
        total++;
        if (msg_valid !== 1'b0 || noc2_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drain valid/ready got=%0b%0b want=01", msg_valid, noc2_ready_out);
        end
        send_flit(64'h4444_0000_0000_0004);
        total++;
        if (msg_valid !== 1'b1 || msg_err !== 1'b1 || msg_len !== 8'd4) begin
            bad++;
            $display("FAIL ovf_flags valid=%0b err=%0b len=%0d want 1 1 4", msg_valid, msg_err, msg_len);
        end
        total++;
        if (msg_data !== 128'h2222_0000_0000_0002_1111_0000_0000_0001) begin
            bad++;
            $display("FAIL ovf_data got=%h want=22220000000000021111000000000001", msg_data);
        end
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_data;
        exp_data = {64'h0, 64'hCAFE_F00D_1234_5678};
        send_flit(mk_hdr(8'd0, 8'd1, 8'h21, 8'h11));
        send_flit(64'hCAFE_F00D_1234_5678);
        noc2_valid_in = 1'b1;
        noc2_data_in  = mk_hdr(8'd0, 8'd0, 8'h22, 8'h12);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (noc2_ready_out !== 1'b0 || msg_valid !== 1'b1 || msg_type !== 8'h21 || msg_mshrid !== 8'h11 ||
                msg_len !== 8'd1 || msg_data !== exp_data || msg_err !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d ready=%0b valid=%0b type=%h mshr=%h len=%0d data=%h err=%0b want 0 1 21 11 1 %h 0",
                         i, noc2_ready_out, msg_valid, msg_type, msg_mshrid, msg_len, msg_data, msg_err, exp_data);
            end
            @(negedge clk);
        end
        msg_ready = 1'b1;
        @(negedge clk);
        total++;
        if (msg_valid !== 1'b0 || noc2_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept valid/ready got=%0b%0b want=01", msg_valid, noc2_ready_out);
        end
        @(negedge clk);
        noc2_valid_in = 1'b0;
        total++;
        if (msg_valid !== 1'b1 || msg_type !== 8'h22 || msg_mshrid !== 8'h12 || msg_data !== 128'h0) begin
            bad++;
            $display("FAIL bp_next valid=%0b type=%h mshr=%h data=%h want 1 22 12 0", msg_valid, msg_type, msg_mshrid, msg_data);
        end
        @(negedge clk);
        msg_ready = 1'b0;
        total++;
        if (msg_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_next_accept valid got=%0b want=0", msg_valid);
        end
    endtask

    task automatic test_reset_mid();
        send_flit(mk_hdr(8'd0, 8'd2, 8'h33, 8'h44));
        send_flit(64'hDEAD_BEEF_0000_0001);
        rst = 1'b1;
        #1;
        total++;
        if (noc2_ready_out !== 1'b1 || msg_valid !== 1'b0 || msg_type !== 8'h00 || msg_mshrid !== 8'h00 ||
            msg_len !== 8'h00 || msg_data !== 128'h0 || msg_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_clear ready=%0b valid=%0b type=%h mshr=%h len=%h data=%h err=%0b want 1 0 0 0 0 0 0",
                     noc2_ready_out, msg_valid, msg_type, msg_mshrid, msg_len, msg_data, msg_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_flit(mk_hdr(8'd0, 8'd1, 8'h44, 8'h09));
        total++;
        if (msg_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_hdr valid got=%0b want=0", msg_valid);
        end
        send_flit(64'h0123_4567_89AB_CDEF);
        total++;
        if (msg_valid !== 1'b1 || msg_type !== 8'h44 || msg_mshrid !== 8'h09 || msg_len !== 8'd1 ||
            msg_data !== {64'h0, 64'h0123_4567_89AB_CDEF}) begin
            bad++;
            $display("FAIL rst_mid_next valid=%0b type=%h mshr=%h len=%0d data=%h want 1 44 09 1 0000000000000000_0123456789abcdef",
                     msg_valid, msg_type, msg_mshrid, msg_len, msg_data);
        end
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;
    endtask

`ifdef NOC2_DEFRAMER_DEST_CHECK_EN
    task automatic test_dest();
        send_flit(mk_hdr(8'd3, 8'd2, 8'h55, 8'h66));
        total++;
        if (msg_valid !== 1'b0 || drop_pulse !== 1'b0) begin
            bad++;
            $display("FAIL drop_hdr valid/drop got=%0b%0b want=00", msg_valid, drop_pulse);
        end
        send_flit(64'h1);
        total++;
        if (msg_valid !== 1'b0 || drop_pulse !== 1'b0) begin
            bad++;
            $display("FAIL drop_flit0 valid/drop got=%0b%0b want=00", msg_valid, drop_pulse);
        end
        send_flit(64'h2);
        total++;
        if (msg_valid !== 1'b0 || drop_pulse !== 1'b1 || noc2_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL drop_pulse valid/drop/ready got=%0b%0b%0b want=011", msg_valid, drop_pulse, noc2_ready_out);
        end
        @(negedge clk);
        total++;
        if (msg_valid !== 1'b0 || drop_pulse !== 1'b0 || noc2_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL drop_after valid/drop/ready got=%0b%0b%0b want=001", msg_valid, drop_pulse, noc2_ready_out);
        end
    endtask
`else
    task automatic test_dest();
        send_flit(mk_hdr(8'd3, 8'd2, 8'h55, 8'h66));
        send_flit(64'h1);
        send_flit(64'h2);
        total++;
        if (msg_valid !== 1'b1 || drop_pulse !== 1'b0 || msg_type !== 8'h55 || msg_data !== {64'h2, 64'h1}) begin
            bad++;
            $display("FAIL dest_ignored valid=%0b drop=%0b type=%h data=%h want 1 0 55 {2,1}", msg_valid, drop_pulse, msg_type, msg_data);
        end
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;
        total++;
        if (msg_valid !== 1'b0 || drop_pulse !== 1'b0) begin
            bad++;
            $display("FAIL dest_ignored_accept valid/drop got=%0b%0b want=00", msg_valid, drop_pulse);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        noc2_valid_in = 1'b0;
        noc2_data_in  = '0;
        msg_ready     = 1'b0;
        chipid        = '0;
        coreid_x      = '0;
        coreid_y      = '0;
        test_reset();
        test_len0();
        test_len2();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_dest();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
